// File: rtl/aead_pkg.sv
// Shared definitions for the AEAD core arbiter: FSM state encoding and the
// layout of the 640-bit request word {key, s, ad, nonce, pt}.
package aead_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int W       = 128;
  localparam int REQ_W   = 640;
  localparam int KEY_LSB = 512;
  localparam int S_LSB   = 384;
  localparam int AD_LSB  = 256;
  localparam int N_LSB   = 128;
  localparam int PT_LSB  = 0;

  // Extract one 128-bit operand from a packed request word.
  function automatic logic [W-1:0] req_field(input logic [REQ_W-1:0] word, input int lsb);
    return word[lsb +: W];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. On a tie the pointer side wins; after any grant
// the pointer moves to the other requester.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic rr_ptr;

  // Pick the winner for this cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (req == 2'b11) gnt_id = rr_ptr;
    else              gnt_id = req[1];
    if (en && (req != 2'b00)) gnt = gnt_id ? 2'b10 : 2'b01;
  end

  // Move the preference away from whoever was just served.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst)        rr_ptr <= 1'b0;
    else if (|gnt)  rr_ptr <= ~gnt_id;
  end

endmodule

// File: rtl/aead_core_arbiter.sv
// Shares one AEAD core between two requesters: round-robin grant, operand
// capture, core reset sequencing, done/timeout handling and a valid/ready
// response channel back to the granted requester.
module aead_core_arbiter
  import aead_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RST_HOLD       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [REQ_W-1:0] req0_data,
  input  logic [REQ_W-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [W-1:0]     rsp_ct,
  output logic             rsp_tag,
  output logic             rsp_err,
  output logic             busy,
  output logic             core_rst,
  output logic [W-1:0]     core_k,
  output logic [W-1:0]     core_s,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_n,
  output logic [W-1:0]     core_p,
  input  logic [W-1:0]     core_c,
  input  logic             core_tag,
  input  logic             core_done
);

  localparam int RUN_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t              state, state_nxt;
  logic [1:0]          gnt;
  logic                gnt_id;
  logic                grant_en;
  logic                granted;
  logic [REQ_W-1:0]    sel_data;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [RUN_W-1:0]    run_cnt;
  logic                hold_done;
  logic                done_seen;
  logic                timeout_hit;
  logic                rsp_fire;

  // Grants are only offered from IDLE and never while reset is asserted.
  assign grant_en = (state == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .en     (grant_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready   = gnt;
  assign granted     = |gnt;
  assign sel_data    = gnt_id ? req1_data : req0_data;
  assign busy        = (state != IDLE);
  assign hold_done   = (hold_cnt == HOLD_MAX);
  // The first RUN cycle (run_cnt == 1) may still see done from a previous job.
  assign done_seen   = (state == RUN) && (run_cnt != RUN_ONE) && core_done;
  assign timeout_hit = (state == RUN) && (run_cnt == RUN_MAX);
  assign rsp_fire    = rsp_valid && rsp_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (granted)                   state_nxt = HOLD;
      HOLD: if (hold_done)                 state_nxt = RUN;
      RUN:  if (done_seen || timeout_hit)  state_nxt = RESP;
      RESP: if (rsp_fire)                  state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // Core reset is registered from the next state so it is glitch-free and only low in RUN.
  always_ff @(posedge clk) begin
    if (rst) core_rst <= 1'b1;
    else     core_rst <= (state_nxt != RUN);
  end

  // HOLD length and RUN length counters; the run counter saturates at the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      run_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          hold_cnt <= granted ? HOLD_ONE : '0;
          run_cnt  <= '0;
        end
        HOLD: begin
          if (!hold_done) hold_cnt <= hold_cnt + HOLD_ONE;
          else            run_cnt  <= RUN_ONE;
        end
        RUN: begin
          if (run_cnt < RUN_MAX) run_cnt <= run_cnt + RUN_ONE;
        end
        default: ;
      endcase
    end
  end

  // Operand registers load only on a grant and otherwise hold for the core.
  always_ff @(posedge clk) begin
    // NOTE: these wide data registers are reset because the core sees them directly; zeroed operands keep it deterministic out of reset.
    if (rst) begin
      core_k <= '0;
      core_s <= '0;
      core_a <= '0;
      core_n <= '0;
      core_p <= '0;
    end else if (granted) begin
      core_k <= req_field(sel_data, KEY_LSB);
      core_s <= req_field(sel_data, S_LSB);
      core_a <= req_field(sel_data, AD_LSB);
      core_n <= req_field(sel_data, N_LSB);
      core_p <= req_field(sel_data, PT_LSB);
    end
  end

  // Response channel: owner set at grant, payload captured on done or timeout, cleared on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_ct    <= '0;
      rsp_tag   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (granted) rsp_id <= gnt_id;
      if (done_seen) begin
        rsp_ct    <= core_c;
        rsp_tag   <= core_tag;
        rsp_err   <= 1'b0;
        rsp_valid <= 1'b1;
      end else if (timeout_hit) begin
        rsp_ct    <= '0;
        rsp_tag   <= 1'b0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aead_core_arbiter.sv
// Randomized self-checking bench for aead_core_arbiter. The reference model is
// a tie-break preference bit plus closed-form latency/payload rules.
module tb_aead_core_arbiter;

  localparam int TO = 64;
  localparam int RH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_ready;
  logic [639:0] req0_data, req1_data;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [127:0] rsp_ct;
  logic         rsp_tag, rsp_err, busy, core_rst;
  logic [127:0] core_k, core_s, core_a, core_n, core_p, core_c;
  logic         core_tag, core_done;

  int n_checks = 0;
  int n_pass   = 0;
  bit pref;  // model: requester that wins when both request

  aead_core_arbiter #(.TIMEOUT_CYCLES(TO), .RST_HOLD(RH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_data (req0_data),
    .req1_data (req1_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_ct    (rsp_ct),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .core_rst  (core_rst),
    .core_k    (core_k),
    .core_s    (core_s),
    .core_a    (core_a),
    .core_n    (core_n),
    .core_p    (core_p),
    .core_c    (core_c),
    .core_tag  (core_tag),
    .core_done (core_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [639:0] rand640();
    logic [639:0] r;
    for (int i = 0; i < 20; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present requests at a negedge, wait for the grant, then follow HOLD into RUN cycle 1.
  task automatic do_grant(input logic [1:0] valids, input logic [639:0] d0, input logic [639:0] d1,
                          output bit g, output logic [639:0] exp_ops, output bit ok);
    int waited = 0;
    int h = 0;
    req_valid = valids;
    req0_data = d0;
    req1_data = d1;
    #1;
    while (req_ready == 2'b00 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    g = (valids == 2'b11) ? pref : valids[1];
    exp_ops = g ? d1 : d0;
    check("grant", req_ready, g ? 2'b10 : 2'b01);
    ok = (req_ready != 2'b00);
    if (!ok) return;
    pref = ~g;
    @(negedge clk);
    check("ready_one_cycle", req_ready, 2'b00);
    req_valid[g] = 1'b0;
    if (g) req1_data = rand640();
    else   req0_data = rand640();
    check("ops_hold", {core_k, core_s, core_a, core_n, core_p}, exp_ops);
    while (core_rst === 1'b1 && h < 20) begin
      h++;
      @(negedge clk);
    end
    check("hold_len", h, RH);
    ok = (core_rst === 1'b0);
  endtask

  // One full job; done_at = RUN cycle where the core raises done (0 = never).
  task automatic run_job(input logic [1:0] valids, input logic [639:0] d0, input logic [639:0] d1,
                         input int done_at, input bit stale, input int bp,
                         input logic [127:0] c, input bit tg);
    bit g, ok, ops_ok, stable, timed_out;
    logic [639:0] ops;
    logic [130:0] payload;
    int k, r, eff, exp_r;
    rsp_ready = (bp == 0);
    core_done = 1'b0;
    core_c    = c;
    core_tag  = tg;
    do_grant(valids, d0, d1, g, ops, ok);
    if (!ok) begin
      req_valid = 2'b00;
      return;
    end
    k = 1; r = 0; ops_ok = 1'b1;
    while (k <= TO + 5) begin
      if (rsp_valid === 1'b1) begin
        r = k;
        break;
      end
      if ({core_k, core_s, core_a, core_n, core_p} !== ops) ops_ok = 1'b0;
      core_done = (done_at != 0 && k >= done_at) || (stale && k == 1);
      @(negedge clk);
      k++;
    end
    eff       = (done_at < 2) ? 2 : done_at;
    timed_out = !(done_at != 0 && eff <= TO);
    exp_r     = timed_out ? TO + 1 : eff + 1;
    check("rsp_latency", r, exp_r);
    check("ops_run", ops_ok, 1'b1);
    if (r == 0) begin
      req_valid = 2'b00;
      return;
    end
    core_c   = rand128();
    core_tag = ~tg;
    check("rsp_id", rsp_id, g);
    check("rsp_err", rsp_err, timed_out);
    check("rsp_ct", rsp_ct, timed_out ? 128'd0 : c);
    check("rsp_tag", rsp_tag, timed_out ? 1'b0 : tg);
    check("core_rst_resp", core_rst, 1'b1);
    payload = {rsp_id, rsp_err, rsp_tag, rsp_ct};
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      core_c = rand128();
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_err, rsp_tag, rsp_ct} !== payload || req_ready !== 2'b00)
        stable = 1'b0;
    end
    if (bp > 0) check("bp_stable", stable, 1'b1);
    check("no_grant_in_resp", req_ready, 2'b00);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_drop_idle", {rsp_valid, busy}, 2'b00);
    rsp_ready = 1'b0;
    core_done = 1'b0;
    req_valid = 2'b00;
  endtask

  initial begin
    bit g, ok;
    logic [639:0] ops, d0;

    rst       = 1'b1;
    req_valid = 2'b11;
    req0_data = rand640();
    req1_data = rand640();
    rsp_ready = 1'b0;
    core_c    = rand128();
    core_tag  = 1'b0;
    core_done = 1'b0;
    pref      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_flags", {rsp_valid, rsp_id, rsp_tag, rsp_err, busy, core_rst}, 6'b000001);
    check("rst_ct", rsp_ct, 128'd0);
    check("rst_ops", {core_k, core_s, core_a, core_n, core_p}, 640'd0);
    rst       = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);

    // Contention: both always requesting, response accepted at once.
    for (int j = 0; j < 4; j++)
      run_job(2'b11, rand640(), rand640(), $urandom_range(1, 30), 1'b0, 0, rand128(), 1'($urandom()));

    // Single job with a fixed key and payload.
    d0 = rand640();
    d0[639:512] = 128'h000000_75747372_71706f6e_6d6c6b6a_69;
    run_job(2'b01, d0, rand640(), 20, 1'b0, 0, {4{32'hA5A5A5A5}}, 1'b1);

    // Timeout, coincident done/timeout, one past timeout, stale done.
    run_job(2'b10, rand640(), rand640(), 0,      1'b0, 0, rand128(), 1'b1);
    run_job(2'b01, rand640(), rand640(), TO,     1'b0, 0, rand128(), 1'b1);
    run_job(2'b01, rand640(), rand640(), TO + 1, 1'b0, 0, rand128(), 1'b1);
    run_job(2'b10, rand640(), rand640(), 10,     1'b1, 0, rand128(), 1'b0);
    run_job(2'b11, rand640(), rand640(), 1,      1'b1, 1, rand128(), 1'b1);

    // Backpressure for 10 cycles with the other requester waiting.
    run_job(2'b11, rand640(), rand640(), 7, 1'b0, 10, rand128(), 1'b1);

    // Randomized mix.
    for (int j = 0; j < 10; j++)
      run_job(2'($urandom_range(1, 3)), rand640(), rand640(), $urandom_range(0, 40),
              1'($urandom()), $urandom_range(0, 4), rand128(), 1'($urandom()));

    // Reset in RUN cycle 5: abort without response, preference back to requester 0.
    rsp_ready = 1'b0;
    core_done = 1'b0;
    do_grant(2'b01, rand640(), rand640(), g, ops, ok);
    if (ok) begin
      repeat (4) @(negedge clk);
      rst = 1'b1;
      core_done = 1'b1;
      @(negedge clk);
      check("midrst_state", {core_rst, rsp_valid, busy}, 3'b100);
      rst = 1'b0;
      core_done = 1'b0;
      pref = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_no_rsp", {rsp_valid, busy}, 2'b00);
    end
    req_valid = 2'b00;
    run_job(2'b11, rand640(), rand640(), 5, 1'b0, 0, rand128(), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
